mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ICACHE_MAX_OUTSTANDING, default 4: maximum in-flight icache loads.
REQ-002 SHALL have parameter NUM_TAGS, default 16: memory tag space, where tag 0 means "none".
REQ-003 SHALL have port clock  in  1  system clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port icache2arb_command  in  2  BUS_NONE or BUS_LOAD only.
REQ-006 SHALL have port icache2arb_addr  in  XLEN  icache request address.
REQ-007 SHALL have port icache_flush  in  1  mispredict squash of in-flight icache loads.
REQ-008 SHALL have port dcache2arb_command / dcache2arb_addr / dcache2arb_data / dcache2arb_size  in  2 / XLEN / 64 / MEM_SIZE  dcache request.
REQ-009 SHALL have port arb2icache_response / arb2icache_tag / arb2icache_data  out  4 / 4 / 64  icache acceptance tag, return tag, return data.
REQ-010 SHALL have port arb2dcache_response / arb2dcache_tag / arb2dcache_data  out  4 / 4 / 64  dcache acceptance tag, return tag, return data.
REQ-011 SHALL have port proc2mem_command / proc2mem_addr / proc2mem_data / proc2mem_size  out  2 / XLEN / 64 / MEM_SIZE  single memory port.
REQ-012 SHALL have port mem2proc_response / mem2proc_tag / mem2proc_data  in  4 / 4 / 64  memory acceptance, return tag, data.

Function
REQ-013 SHALL drive the memory port combinationally from exactly one granted requester per cycle; with no grant, proc2mem_command=BUS_NONE and addr/data/size=0.
REQ-014 SHALL treat the icache as eligible only if its command is BUS_LOAD, its outstanding count < ICACHE_MAX_OUTSTANDING, and icache_flush=0.
REQ-015 SHALL grant the dcache over the icache on conflict (fixed priority) unless MEM_ARB_RR_EN is defined.
REQ-016 SHALL pass mem2proc_response to the granted requester's *_response in the same cycle; the non-granted requester sees 0. A 0 response means rejected, and the requester retries.
REQ-017 SHALL, on an accepted load (response != 0), record owner and valid for that tag in the tag table at the next posedge.
REQ-018 SHALL NOT record accepted stores; a store needs no return routing.
REQ-019 SHALL, when mem2proc_tag != 0 and that entry is valid, forward the tag and data to the owner in the same cycle, clear the entry, and give 0 tag to the other requester.
REQ-020 SHALL ignore a mem2proc_tag that hits an invalid entry: both *_tag outputs are 0 and no state changes.
REQ-021 SHALL, if a return and a new allocation hit the same tag in one cycle, clear the old entry and then set it, so the new allocation wins.
REQ-022 SHALL, on icache_flush, mark every valid icache-owned entry stale; a later return of a stale entry is cleared and not forwarded (arb2icache_tag=0).
REQ-023 SHALL drop an icache-owned return that arrives in the same cycle as icache_flush.
REQ-024 SHALL increment the icache outstanding counter on an accepted icache load and decrement it on any icache-owned return, stale or not; both in one cycle leaves it unchanged.
REQ-025 SHALL treat counter saturation at ICACHE_MAX_OUTSTANDING as back-pressure only, never wrap.

Reset
REQ-026 SHALL, while reset is high, force proc2mem_command=BUS_NONE and all *_response and *_tag outputs to 0.
REQ-027 SHALL clear on reset all valid and stale bits, the outstanding counter to 0, and last_grant to ICACHE (so the dcache wins first).
REQ-028 SHALL discard, after reset deasserts, any return for a pre-reset tag (entry invalid).

Configuration
REQ-029 SHALL implement round-robin arbitration when MEM_ARB_RR_EN is defined: on conflict, grant the requester not in last_grant; last_grant updates only on an accepted request. Without the macro, SHALL use fixed dcache priority and no last_grant register.

Structure
REQ-030 SHALL place BUS_COMMAND, MEM_SIZE, the ARB_OWNER enum (ICACHE/DCACHE) and MEM_TAG_LEN=4 in the shared package.
REQ-031 SHALL contain the owner/valid/stale arrays in one sub-module, mem_arb_tag_table (alloc, free, flush ports; lookup output).

Verification
REQ-032 SHALL be verified with: icache load 0x100 and dcache load 0x200 in the same cycle, mem response 3 -> dcache granted, arb2dcache_response=3, arb2icache_response=0.
REQ-033 SHALL be verified with: icache load accepted as tag 5, later mem2proc_tag=5 with data 0xDEAD -> arb2icache_tag=5, data 0xDEAD, arb2dcache_tag=0.
REQ-034 SHALL be verified with: dcache store accepted as tag 2, then mem2proc_tag=2 -> neither requester sees tag 2.
REQ-035 SHALL be verified with: icache tags 1 and 4 in flight, then icache_flush, then returns 1 and 4 -> both dropped, counter returns to 0.
REQ-036 SHALL be verified with: 4 icache loads accepted, none returned -> 5th icache request not granted (proc2mem_command=BUS_NONE); one return -> request granted next cycle.
REQ-037 SHALL be verified with MEM_ARB_RR_EN defined: continuous requests from both, every request accepted -> grants alternate D, I, D, I; with responses of 0, the grant stays with the dcache.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus command, size, owner and tag definitions for the memory arbiter.
package mem_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int MEM_TAG_LEN = 4;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} ARB_OWNER;
  typedef logic [MEM_TAG_LEN-1:0] mem_tag_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and memory-port signals; slave is the arbiter side, master the environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  BUS_COMMAND icache2arb_command;
  logic [XLEN-1:0] icache2arb_addr;
  logic icache_flush;
  BUS_COMMAND dcache2arb_command;
  logic [XLEN-1:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  MEM_SIZE dcache2arb_size;
  mem_tag_t arb2icache_response;
  mem_tag_t arb2icache_tag;
  logic [63:0] arb2icache_data;
  mem_tag_t arb2dcache_response;
  mem_tag_t arb2dcache_tag;
  logic [63:0] arb2dcache_data;
  BUS_COMMAND proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  MEM_SIZE proc2mem_size;
  mem_tag_t mem2proc_response;
  mem_tag_t mem2proc_tag;
  logic [63:0] mem2proc_data;
  modport slave (
    input icache2arb_command, icache2arb_addr, icache_flush,
    input dcache2arb_command, dcache2arb_addr, dcache2arb_data, dcache2arb_size,
    input mem2proc_response, mem2proc_tag, mem2proc_data,
    output arb2icache_response, arb2icache_tag, arb2icache_data,
    output arb2dcache_response, arb2dcache_tag, arb2dcache_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
  modport master (
    output icache2arb_command, icache2arb_addr, icache_flush,
    output dcache2arb_command, dcache2arb_addr, dcache2arb_data, dcache2arb_size,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input arb2icache_response, arb2icache_tag, arb2icache_data,
    input arb2dcache_response, arb2dcache_tag, arb2dcache_data,
    input proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
endinterface

// File: rtl/mem_arbiter_tag_table.sv
// mem_arb_tag_table: per-tag owner/valid/stale state; free, then flush, then alloc so a same-cycle realloc wins.
module mem_arb_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en,
  input  mem_tag_t alloc_tag,
  input  ARB_OWNER alloc_owner,
  input  logic     free_en,
  input  mem_tag_t free_tag,
  input  logic     flush,
  input  mem_tag_t lookup_tag,
  output logic     lookup_valid,
  output logic     lookup_stale,
  output ARB_OWNER lookup_owner
);
  logic [NUM_TAGS-1:0] r_valid;
  logic [NUM_TAGS-1:0] r_stale;
  ARB_OWNER r_owner [NUM_TAGS];
  assign lookup_valid = r_valid[lookup_tag];
  assign lookup_stale = r_stale[lookup_tag];
  assign lookup_owner = r_owner[lookup_tag];
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_stale <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_en && alloc_tag == mem_tag_t'(i)) begin
          r_valid[i] <= 1'b1;
          r_stale[i] <= 1'b0;
          r_owner[i] <= alloc_owner;
        end else if (free_en && free_tag == mem_tag_t'(i)) begin
          r_valid[i] <= 1'b0;
          r_stale[i] <= 1'b0;
        end else if (flush && r_valid[i] && r_owner[i] == ICACHE) begin
          r_stale[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache and routes tagged returns to the owner.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise the dcache has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ICACHE_MAX_OUTSTANDING = 4,
  parameter int NUM_TAGS = 16
) (
  input logic clock,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(ICACHE_MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(ICACHE_MAX_OUTSTANDING);
  logic [CW-1:0] r_outstanding;
  logic w_i_elig, w_d_elig, w_grant_valid, w_accept, w_i_accept, w_alloc;
  logic w_hit, w_i_ret, w_fwd, w_lk_valid, w_lk_stale;
  ARB_OWNER w_grant, w_lk_owner;
  assign w_i_elig = bus.icache2arb_command == BUS_LOAD && r_outstanding < MAX_OUT && !bus.icache_flush;
  assign w_d_elig = bus.dcache2arb_command != BUS_NONE;
  assign w_grant_valid = !reset && (w_i_elig || w_d_elig);
`ifdef MEM_ARB_RR_EN
  ARB_OWNER r_last_grant;
  assign w_grant = (w_i_elig && w_d_elig) ? (r_last_grant == DCACHE ? ICACHE : DCACHE)
                                          : (w_d_elig ? DCACHE : ICACHE);
  always_ff @(posedge clock) begin
    if (reset) r_last_grant <= ICACHE;
    else if (w_accept) r_last_grant <= w_grant;
  end
`else
  assign w_grant = w_d_elig ? DCACHE : ICACHE;
`endif
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr = '0;
    bus.proc2mem_data = '0;
    bus.proc2mem_size = BYTE;
    if (w_grant_valid && w_grant == DCACHE) begin
      bus.proc2mem_command = bus.dcache2arb_command;
      bus.proc2mem_addr = bus.dcache2arb_addr;
      bus.proc2mem_data = bus.dcache2arb_data;
      bus.proc2mem_size = bus.dcache2arb_size;
    end else if (w_grant_valid) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr = bus.icache2arb_addr;
      bus.proc2mem_size = DOUBLE;
    end
  end
  assign bus.arb2dcache_response = (w_grant_valid && w_grant == DCACHE) ? bus.mem2proc_response : '0;
  assign bus.arb2icache_response = (w_grant_valid && w_grant == ICACHE) ? bus.mem2proc_response : '0;
  assign w_accept = w_grant_valid && bus.mem2proc_response != '0;
  assign w_i_accept = w_accept && w_grant == ICACHE;
  assign w_alloc = w_accept && bus.proc2mem_command == BUS_LOAD;
  // A return to a stale entry, or an icache return racing a flush, frees the tag but is not delivered.
  assign w_hit = !reset && bus.mem2proc_tag != '0 && w_lk_valid;
  assign w_i_ret = w_hit && w_lk_owner == ICACHE;
  assign w_fwd = w_hit && !w_lk_stale && !(w_i_ret && bus.icache_flush);
  assign bus.arb2icache_tag = (w_fwd && w_lk_owner == ICACHE) ? bus.mem2proc_tag : '0;
  assign bus.arb2dcache_tag = (w_fwd && w_lk_owner == DCACHE) ? bus.mem2proc_tag : '0;
  assign bus.arb2icache_data = (w_fwd && w_lk_owner == ICACHE) ? bus.mem2proc_data : '0;
  assign bus.arb2dcache_data = (w_fwd && w_lk_owner == DCACHE) ? bus.mem2proc_data : '0;
  always_ff @(posedge clock) begin
    if (reset) r_outstanding <= '0;
    else if (w_i_accept && !w_i_ret && r_outstanding != MAX_OUT) r_outstanding <= r_outstanding + CW'(1);
    else if (w_i_ret && !w_i_accept && r_outstanding != '0) r_outstanding <= r_outstanding - CW'(1);
  end
  mem_arb_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tags (
    .clock(clock),
    .reset(reset),
    .alloc_en(w_alloc),
    .alloc_tag(bus.mem2proc_response),
    .alloc_owner(w_grant),
    .free_en(w_hit),
    .free_tag(bus.mem2proc_tag),
    .flush(bus.icache_flush && !reset),
    .lookup_tag(bus.mem2proc_tag),
    .lookup_valid(w_lk_valid),
    .lookup_stale(w_lk_stale),
    .lookup_owner(w_lk_owner)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed arbitration sequence and randomized run against a tag-table model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  typedef struct {
    logic rst; BUS_COMMAND ic; logic [XLEN-1:0] ia; logic fl;
    BUS_COMMAND dc; logic [XLEN-1:0] da; logic [63:0] dd; MEM_SIZE dsz;
    logic [3:0] rsp; logic [3:0] rtag; logic [63:0] rdat;
  } stim_t;
  typedef struct {
    BUS_COMMAND cmd; logic [XLEN-1:0] addr; logic [63:0] data; MEM_SIZE sz;
    logic [3:0] ir; logic [3:0] dr; logic [3:0] it; logic [3:0] dt; logic [63:0] idat; logic [63:0] ddat;
  } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  bit m_val [16];
  bit m_stale [16];
  ARB_OWNER m_own [16];
  ARB_OWNER m_last = ICACHE;
  int m_cnt = 0;
  mem_arbiter_if bus();
  mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, x, $time);
    end
  endtask

  // Reference: outstanding icache loads as a count, in-flight tags as owner/stale arrays.
  task automatic model(input stim_t s, output exp_t e, output int g);
    bit ie, de, hit;
    int t;
    e = '{cmd: BUS_NONE, sz: BYTE, default: '0};
    ie = !s.rst && s.ic == BUS_LOAD && m_cnt < 4 && !s.fl;
    de = !s.rst && s.dc != BUS_NONE;
    g = (ie && de) ? ((RR && m_last == DCACHE) ? 1 : 2) : de ? 2 : ie ? 1 : 0;
    if (g == 2) begin e.cmd = s.dc; e.addr = s.da; e.data = s.dd; e.sz = s.dsz; e.dr = s.rsp; end
    if (g == 1) begin e.cmd = BUS_LOAD; e.addr = s.ia; e.ir = s.rsp; end
    t = int'(s.rtag);
    hit = !s.rst && t != 0 && m_val[t];
    if (hit && !m_stale[t] && !(m_own[t] == ICACHE && s.fl)) begin
      if (m_own[t] == ICACHE) begin e.it = s.rtag; e.idat = s.rdat; end
      else begin e.dt = s.rtag; e.ddat = s.rdat; end
    end
    if (s.rst) begin
      m_val = '{default: 1'b0};
      m_stale = '{default: 1'b0};
      m_cnt = 0;
      m_last = ICACHE;
    end else begin
      if (hit) begin
        if (m_own[t] == ICACHE) m_cnt--;
        m_val[t] = 1'b0;
        m_stale[t] = 1'b0;
      end
      if (s.fl) foreach (m_val[i]) if (m_val[i] && m_own[i] == ICACHE) m_stale[i] = 1'b1;
      if (g != 0 && s.rsp != 0) begin
        m_last = (g == 1) ? ICACHE : DCACHE;
        if (g == 1) m_cnt++;
        if (e.cmd == BUS_LOAD) begin m_val[s.rsp] = 1'b1; m_stale[s.rsp] = 1'b0; m_own[s.rsp] = m_last; end
      end
    end
  endtask

  task automatic run(input stim_t s, output exp_t e, output int g);
    reset = s.rst;
    bus.icache2arb_command = s.ic;
    bus.icache2arb_addr = s.ia;
    bus.icache_flush = s.fl;
    bus.dcache2arb_command = s.dc;
    bus.dcache2arb_addr = s.da;
    bus.dcache2arb_data = s.dd;
    bus.dcache2arb_size = s.dsz;
    bus.mem2proc_response = s.rsp;
    bus.mem2proc_tag = s.rtag;
    bus.mem2proc_data = s.rdat;
    @(negedge clock);
    model(s, e, g);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string n, input exp_t x, input bit full);
    cmp({n, ".cmd"}, 64'(bus.proc2mem_command), 64'(x.cmd));
    cmp({n, ".addr"}, 64'(bus.proc2mem_addr), 64'(x.addr));
    cmp({n, ".i_resp"}, 64'(bus.arb2icache_response), 64'(x.ir));
    cmp({n, ".d_resp"}, 64'(bus.arb2dcache_response), 64'(x.dr));
    cmp({n, ".i_tag"}, 64'(bus.arb2icache_tag), 64'(x.it));
    cmp({n, ".d_tag"}, 64'(bus.arb2dcache_tag), 64'(x.dt));
    if (x.it != 0) cmp({n, ".i_data"}, bus.arb2icache_data, x.idat);
    if (x.dt != 0) cmp({n, ".d_data"}, bus.arb2dcache_data, x.ddat);
    if (full) begin
      cmp({n, ".data"}, bus.proc2mem_data, x.data);
      cmp({n, ".size"}, 64'(bus.proc2mem_size), 64'(x.sz));
    end
  endtask

  function automatic vec_t v(input logic r, input BUS_COMMAND ic, input logic [31:0] ia, input logic fl,
                             input BUS_COMMAND dc, input logic [31:0] da, input logic [63:0] dd,
                             input logic [3:0] rsp, input logic [3:0] rtag, input logic [63:0] rdat,
                             input BUS_COMMAND ec, input logic [31:0] ea, input logic [3:0] eir,
                             input logic [3:0] edr, input logic [3:0] eit, input logic [3:0] edt);
    vec_t r_v;
    r_v.s = '{rst: r, ic: ic, ia: ia, fl: fl, dc: dc, da: da, dd: dd, dsz: WORD, rsp: rsp, rtag: rtag, rdat: rdat};
    r_v.e = '{cmd: ec, addr: ea, data: '0, sz: BYTE, ir: eir, dr: edr, it: eit, dt: edt,
              idat: (eit != 0) ? rdat : 64'h0, ddat: (edt != 0) ? rdat : 64'h0};
    return r_v;
  endfunction

  initial begin
    vec_t tbl[$];
    stim_t s;
    exp_t m;
    int g;
    bit want_d;
    tbl.push_back(v(1, BUS_LOAD, 'h100, 0, BUS_LOAD, 'h200, 0, 3, 0, 0, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 5, 'h55, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h100, 0, BUS_LOAD, 'h200, 0, 3, 0, 0, BUS_LOAD, 'h200, 0, 3, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h104, 0, BUS_NONE, 0, 0, 5, 0, 0, BUS_LOAD, 'h104, 5, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 5, 'hDEAD, BUS_NONE, 0, 0, 0, 5, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_STORE, 'h300, 'h1234, 2, 0, 0, BUS_STORE, 'h300, 0, 2, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 2, 'h22, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 3, 'hBEEF, BUS_NONE, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, BUS_LOAD, 'h110, 0, BUS_NONE, 0, 0, 1, 0, 0, BUS_LOAD, 'h110, 1, 0, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h114, 0, BUS_NONE, 0, 0, 4, 0, 0, BUS_LOAD, 'h114, 4, 0, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h118, 1, BUS_NONE, 0, 0, 6, 0, 0, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 1, 'h11, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 4, 'h44, BUS_NONE, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, BUS_LOAD, 32'h120 + 32'(4 * k), 0, BUS_NONE, 0, 0, 4'(7 + k), 0, 0,
                      BUS_LOAD, 32'h120 + 32'(4 * k), 4'(7 + k), 0, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h130, 0, BUS_NONE, 0, 0, 11, 0, 0, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h130, 0, BUS_NONE, 0, 0, 11, 7, 'h77, BUS_NONE, 0, 0, 0, 7, 0));
    tbl.push_back(v(0, BUS_LOAD, 'h130, 0, BUS_NONE, 0, 0, 11, 0, 0, BUS_LOAD, 'h130, 11, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 1, BUS_NONE, 0, 0, 0, 8, 'h88, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 8, 'h88, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_LOAD, 'h400, 0, 12, 0, 0, BUS_LOAD, 'h400, 0, 12, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_LOAD, 'h404, 0, 12, 12, 'hC, BUS_LOAD, 'h404, 0, 12, 0, 12));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 12, 'hD, BUS_NONE, 0, 0, 0, 0, 12));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 12, 'hE, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_LOAD, 'h500, 0, 13, 0, 0, BUS_LOAD, 'h500, 0, 13, 0, 0));
    tbl.push_back(v(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 13, 'h13, BUS_NONE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 13, 'h13, BUS_NONE, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    foreach (tbl[i]) begin
      run(tbl[i].s, m, g);
      check_out($sformatf("vec%0d", i), tbl[i].e, 1'b0);
      advance();
    end
    s = '{rst: 1'b1, ic: BUS_NONE, dc: BUS_NONE, dsz: WORD, default: '0};
    run(s, m, g);
    advance();
    for (int k = 0; k < 7; k++) begin
      s = '{rst: 1'b0, ic: BUS_LOAD, ia: 'h1000, dc: BUS_LOAD, da: 'h2000, dsz: WORD,
            rsp: (k < 4) ? 4'(k + 1) : 4'h0, default: '0};
      run(s, m, g);
      want_d = !RR || k >= 4 || k % 2 == 0;
      cmp($sformatf("alt%0d.addr", k), 64'(bus.proc2mem_addr), want_d ? 64'h2000 : 64'h1000);
      cmp($sformatf("alt%0d.d_resp", k), 64'(bus.arb2dcache_response), want_d ? 64'(s.rsp) : 64'h0);
      cmp($sformatf("alt%0d.i_resp", k), 64'(bus.arb2icache_response), want_d ? 64'h0 : 64'(s.rsp));
      advance();
    end
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 5);
      s.rst = (i < 2) || ($urandom_range(0, 299) == 0);
      s.ic = ($urandom_range(0, 3) != 0) ? BUS_LOAD : BUS_NONE;
      s.ia = $urandom;
      s.fl = ($urandom_range(0, 29) == 0);
      s.dc = (r == 0) ? BUS_LOAD : (r == 1) ? BUS_STORE : BUS_NONE;
      s.da = $urandom;
      s.dd = {$urandom, $urandom};
      s.dsz = MEM_SIZE'($urandom_range(0, 3));
      s.rsp = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      s.rtag = 4'($urandom_range(0, 15));
      s.rdat = {$urandom, $urandom};
      run(s, m, g);
      check_out($sformatf("rnd%0d", i), m, g != 1);
      advance();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
